// File: rtl/axi_pkg.sv
// Shared AXI read-master types: FSM states and AR/R channel encodings.
`include "AXI_define.svh"
package axi_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/AXI_define.svh
// Bus widths shared by the AXI read path.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ADDR_W 32
`define AXI_DATA_W 32
`define AXI_ID_W   4
`define AXI_LEN_W  4
`endif

// File: rtl/axi_read_master.sv
// Single-outstanding AXI INCR read master; R beats pass straight to the core with zero latency.
// Backpressure: rsp_ready drives RREADY directly, nothing is buffered; one idle cycle between bursts.
`include "AXI_define.svh"
module axi_read_master
    import axi_pkg::*;
#(
    parameter logic [`AXI_ID_W-1:0] MASTER_ID = 4'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [`AXI_ADDR_W-1:0] req_addr,
    input  logic [`AXI_LEN_W-1:0]  req_len,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [`AXI_DATA_W-1:0] rsp_data,
    output logic                   rsp_last,
    output logic                   rsp_err,
    output logic [`AXI_ID_W-1:0]   ARID,
    output logic [`AXI_ADDR_W-1:0] ARADDR,
    output logic [`AXI_LEN_W-1:0]  ARLEN,
    output logic [2:0]             ARSIZE,
    output logic [1:0]             ARBURST,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [`AXI_ID_W-1:0]   RID,
    input  logic [`AXI_DATA_W-1:0] RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RLAST,
    input  logic                   RVALID,
    output logic                   RREADY
);

    rd_state_e              state_q, state_d;
    logic [`AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [`AXI_LEN_W-1:0]  len_q, len_d;
    logic [`AXI_LEN_W-1:0]  cnt_q, cnt_d;

    logic req_hs;
    logic ar_hs;
    logic r_hs;
    logic beat_last;

    assign req_hs    = req_valid & req_ready;
    assign ar_hs     = ARVALID & ARREADY;
    assign r_hs      = RVALID & RREADY;
    assign beat_last = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Termination follows our own beat count; RLAST only feeds rsp_err.
                if (r_hs) begin
                    if (beat_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);

    assign ARVALID = (state_q == ST_ADDR);
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARID    = MASTER_ID;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;

    assign RREADY    = (state_q == ST_DATA) & rsp_ready;
    assign rsp_valid = (state_q == ST_DATA) & RVALID;
    assign rsp_data  = RDATA;
    assign rsp_last  = beat_last;
    assign rsp_err   = (RRESP != AXI_RESP_OKAY) | (RLAST != beat_last) | (RID != MASTER_ID);

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: the bench plays the AXI slave and the core.
`timescale 1ns/1ps
module tb_axi_read_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;

    axi_read_master #(.MASTER_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Request in IDLE, then hold ARREADY low for ar_wait cycles before the AR handshake.
    task automatic issue(input logic [31:0] addr, input logic [3:0] len, input int ar_wait);
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_len = len; ARREADY = 1'b0; RVALID = 1'b0;
        #1 chk("req_ready_idle", req_ready, 1);
        chk("arvalid_idle", ARVALID, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hDEAD_BEE0; req_len = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < ar_wait; i++) begin
            #1 chk("arvalid_wait", ARVALID, 1);
            chk("araddr_wait", ARADDR, addr);
            chk("arlen_wait", ARLEN, len);
            chk("rready_wait", RREADY, 0);
            chk("req_ready_wait", req_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        ARREADY = 1'b1;
        #1 chk("arvalid", ARVALID, 1);
        chk("araddr", ARADDR, addr);
        chk("arlen", ARLEN, len);
        chk("arid", ARID, 0);
        chk("arsize", ARSIZE, 3'b010);
        chk("arburst", ARBURST, 2'b01);
        @(posedge clk);
        @(negedge clk);
        ARREADY = 1'b0;
    endtask

    // One cycle on the R channel with the given core ready and slave beat.
    task automatic beat(input logic rdy, input logic [31:0] data, input logic rlast,
                        input logic [1:0] resp, input logic [3:0] rid,
                        input logic exp_last, input logic exp_err);
        @(negedge clk);
        rsp_ready = rdy; RVALID = 1'b1; RDATA = data; RLAST = rlast; RRESP = resp; RID = rid;
        #1 chk("rsp_valid", rsp_valid, 1);
        chk("rready", RREADY, rdy);
        chk("rsp_data", rsp_data, data);
        chk("rsp_last", rsp_last, exp_last);
        chk("rsp_err", rsp_err, exp_err);
        @(posedge clk);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        RVALID = 1'b0; rsp_ready = 1'b1;
        #1 chk(tag, req_ready, 1);
        chk("rready_idle", RREADY, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1; RVALID = 1'b1;
        #1 chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_arlen", ARLEN, 0);

        // Basic 4-beat burst, no stalls.
        issue(32'h0000_1000, 4'd3, 0);
        for (int i = 0; i < 4; i++)
            beat(1'b1, 32'hA0 + i, (i == 3), 2'b00, 4'd0, (i == 3), 1'b0);
        expect_idle("idle_after_basic");

        // ARREADY held low for 5 cycles, single beat.
        issue(32'h0000_2000, 4'd0, 5);
        beat(1'b1, 32'hB0, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        expect_idle("idle_after_arwait");

        // Core stalls: rsp_ready 1,0,0,1 over a 2-beat burst.
        issue(32'h0000_3000, 4'd1, 0);
        beat(1'b1, 32'hC0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        beat(1'b0, 32'hC1, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        beat(1'b0, 32'hC1, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        beat(1'b1, 32'hC1, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        expect_idle("idle_after_stall");

        // Early RLAST on the third beat is flagged but the burst runs to 4 beats.
        issue(32'h0000_4000, 4'd3, 0);
        beat(1'b1, 32'hD0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        beat(1'b1, 32'hD1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        beat(1'b1, 32'hD2, 1'b1, 2'b00, 4'd0, 1'b0, 1'b1);
        beat(1'b1, 32'hD3, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        expect_idle("idle_after_early_last");

        // SLVERR on a single-beat burst.
        issue(32'h0000_5000, 4'd0, 0);
        beat(1'b1, 32'hE0, 1'b1, 2'b10, 4'd0, 1'b1, 1'b1);
        expect_idle("idle_after_slverr");

        // Wrong RID is an error; final beat overlaps a new request which must wait a cycle.
        issue(32'h0000_6000, 4'd0, 0);
        @(negedge clk);
        rsp_ready = 1'b1; RVALID = 1'b1; RDATA = 32'hF0; RLAST = 1'b1; RRESP = 2'b00; RID = 4'd3;
        req_valid = 1'b1; req_addr = 32'h0000_7000; req_len = 4'd0;
        #1 chk("rid_err", rsp_err, 1);
        chk("bubble_req_ready", req_ready, 0);
        @(posedge clk);
        RID = 4'd0;
        issue(32'h0000_7000, 4'd0, 0);
        beat(1'b1, 32'hF1, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        expect_idle("idle_after_bubble");

        // Reset after two beats abandons the burst.
        issue(32'h0000_8000, 4'd3, 0);
        beat(1'b1, 32'h10, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        beat(1'b1, 32'h11, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; RVALID = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rready", RREADY, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        issue(32'h0000_9000, 4'd0, 0);
        beat(1'b1, 32'h20, 1'b1, 2'b00, 4'd0, 1'b1, 1'b0);
        expect_idle("idle_after_midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 Parameter MASTER_ID, default 4'd0, ARID driven on every burst.
REQ-002 Reset is rst, synchronous, active-high; clock is clk.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  core read request.
REQ-006 req_ready  out  1  request accepted this cycle when both high.
REQ-007 req_addr  in  32  byte start address, word-aligned.
REQ-008 req_len  in  4  beats minus one (AXI ARLEN encoding).
REQ-009 rsp_valid  out  1  read beat available to core.
REQ-010 rsp_ready  in  1  core accepts beat.
REQ-011 rsp_data  out  32  beat data.
REQ-012 rsp_last  out  1  final beat of burst.
REQ-013 rsp_err  out  1  beat carries error (RRESP not OKAY, or protocol mismatch).
REQ-014 ARID out 4, ARADDR out 32, ARLEN out 4, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1: AXI read-address channel.
REQ-015 RID in 4, RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1: AXI read-data channel.

Function
REQ-016 FSM states IDLE, ADDR, DATA; IDLE->ADDR on req_valid&req_ready; ADDR->DATA on ARVALID&ARREADY; DATA->IDLE on R handshake of beat with cnt==len_q.
REQ-017 req_ready = 1 only in IDLE; addr_q/len_q latched on request handshake.
REQ-018 ARVALID = 1 only in ADDR; ARADDR=addr_q, ARLEN=len_q, ARID=MASTER_ID, ARSIZE=3'b010, ARBURST=2'b01 (INCR), all stable while ARVALID high.
REQ-019 No AR issued before previous burst's final beat completes (one outstanding burst).
REQ-020 RREADY = (state==DATA) & rsp_ready; rsp_valid = (state==DATA) & RVALID; rsp_data=RDATA, combinational pass-through, zero latency.
REQ-021 4-bit beat counter cnt: cleared on AR handshake, +1 on each R handshake; never wraps (max 15 = len 15).
REQ-022 rsp_last = (cnt==len_q), independent of RLAST.
REQ-023 rsp_err = (RRESP!=2'b00) | (RLAST != (cnt==len_q)) | (RID != MASTER_ID).
REQ-024 Burst terminates on rsp_last beat even if RLAST absent; early RLAST flagged by rsp_err and ignored for termination.
REQ-025 Final-beat handshake and new req_valid same cycle: request not accepted; accepted next cycle in IDLE (one-cycle bubble, intentional).
REQ-026 rsp_ready low stalls RREADY; RDATA held by slave, no internal buffering.

Reset
REQ-027 On rst: state=IDLE, cnt=0, addr_q=0, len_q=0; ARVALID=0, RREADY=0, rsp_valid=0, req_ready=1 next cycle.
REQ-028 Reset mid-burst abandons burst; no residual beat delivered to core after reset.

Structure
REQ-029 Width macros from AXI_define.svh; FSM state enum and ARSIZE/ARBURST/RESP constants in shared package axi_pkg.
REQ-030 Single module; no sub-modules.

Verification
REQ-031 req addr=0x1000 len=3, slave ARREADY immediate, 4 beats no stall -> ARLEN=3, rsp_last on 4th beat only, back to IDLE, rsp_err=0.
REQ-032 ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5, no RREADY until AR handshake.
REQ-033 rsp_ready toggled 1,0,0,1 during len=1 burst -> RREADY mirrors, cnt advances only on handshakes, 2 beats delivered.
REQ-034 Slave asserts RLAST on beat 2 of len=3 -> rsp_err=1 that beat, burst continues to 4th beat.
REQ-035 RRESP=2'b10 on beat 0, len=0 -> rsp_err=1, rsp_last=1, IDLE next cycle.
REQ-036 rst asserted mid-DATA after 2 beats -> next cycle IDLE, RREADY=0, rsp_valid=0, new request accepted with cnt=0.
